// File: rtl/fifo_rd_pkg.sv
// Shared types and constants for the FIFO burst read controller.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package fifo_rd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } fifo_rd_state_t;

    // Two slots: one word being offered downstream plus one landing from the FIFO.
    localparam int FIFO_RD_SKID_DEPTH = 2;
    localparam int FIFO_RD_STALL_W    = 16;

endpackage

// File: rtl/fifo_rd_skid.sv
// 2-entry valid/ready skid buffer between the FIFO pop strobe and the output stream.
// Latency: a word pushed at edge k is offered (o_valid=1) in the cycle after edge k.
// Backpressure: caller must only push when a slot is free after this cycle's pop.
//
// Ports:
//   i_clk, i_rst_n        clock, async active-low reset
//   i_clear               synchronous flush of all entries
//   i_push, i_push_data   write one word
//   o_data, o_valid,      stream output (oldest word first)
//   i_ready
//   o_occupancy           number of buffered words (0..2)
module fifo_rd_skid
    import fifo_rd_pkg::*;
#(
    parameter int DATA_SIZE = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_clear,
    input  logic                 i_push,
    input  logic [DATA_SIZE-1:0] i_push_data,
    output logic [DATA_SIZE-1:0] o_data,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [1:0]           o_occupancy
);

    logic [DATA_SIZE-1:0] r_mem [FIFO_RD_SKID_DEPTH];
    logic                 r_wr_ptr;
    logic                 r_rd_ptr;
    logic [1:0]           r_occ;
    logic                 w_pop;

    assign w_pop       = (r_occ != 2'd0) && i_ready;
    assign o_valid     = (r_occ != 2'd0);
    assign o_data      = r_mem[r_rd_ptr];
    assign o_occupancy = r_occ;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < FIFO_RD_SKID_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_occ    <= 2'd0;
        end else if (i_clear) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_occ    <= 2'd0;
        end else begin
            // When full, a push is only legal alongside a pop, so the slot
            // being overwritten is the one leaving on this same edge.
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({i_push, w_pop})
                2'b10:   r_occ <= r_occ + 2'd1;
                2'b01:   r_occ <= r_occ - 2'd1;
                default: r_occ <= r_occ;
            endcase
        end
    end

endmodule

// File: rtl/fifo_burst_reader.sv
// Pops a commanded number of words from a show-ahead FIFO onto a valid/ready stream.
// Latency: word popped at edge k is valid the next cycle; N-word burst done at cycle N+2.
// Backpressure: 2-entry skid absorbs i_ready drops; pop stalls only when skid stays full.
//
// Ports:
//   i_clk, i_rst_n            clock, async active-low reset
//   i_start, i_len            burst command (accepted only in IDLE)
//   o_busy, o_done            status; o_done is a one-cycle completion pulse
//   o_remaining               words still to pop (0 outside RUN)
//   i_fifo_data, i_fifo_empty show-ahead FIFO read side
//   o_fifo_read               pop strobe (combinational)
//   o_data, o_valid, i_ready  output stream
//   o_stall_cycles            FIFO starvation count, only with FIFO_RD_STALL_CNT_EN
module fifo_burst_reader
    import fifo_rd_pkg::*;
#(
    parameter int DATA_SIZE = 16,
    parameter int LEN_W     = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_start,
    input  logic [LEN_W-1:0]           i_len,
    output logic                       o_busy,
    output logic                       o_done,
    output logic [LEN_W-1:0]           o_remaining,
    input  logic [DATA_SIZE-1:0]       i_fifo_data,
    input  logic                       i_fifo_empty,
    output logic                       o_fifo_read,
    output logic [DATA_SIZE-1:0]       o_data,
    output logic                       o_valid,
    input  logic                       i_ready
`ifdef FIFO_RD_STALL_CNT_EN
    ,
    output logic [FIFO_RD_STALL_W-1:0] o_stall_cycles
`endif
);

    localparam logic [1:0] SKID_FULL = 2'(FIFO_RD_SKID_DEPTH);

    fifo_rd_state_t   r_state;
    fifo_rd_state_t   w_state_nxt;
    logic [LEN_W-1:0] r_remaining;
    logic [1:0]       w_occ;
    logic             w_start_acc;
    logic             w_xfer;
    logic             w_slot_free;
    logic             w_read;
    logic             w_skid_clear;

    assign w_start_acc  = (r_state == IDLE) && i_start;
    assign w_skid_clear = w_start_acc && (i_len != '0);
    assign w_xfer       = o_valid && i_ready;
    // A full skid still has room if its head leaves this cycle.
    assign w_slot_free  = (w_occ < SKID_FULL) || ((w_occ == SKID_FULL) && w_xfer);
    assign w_read       = (r_state == RUN) && !i_fifo_empty
                          && (r_remaining != '0) && w_slot_free;
    assign o_fifo_read  = w_read;
    assign o_remaining  = (r_state == RUN) ? r_remaining : '0;

    fifo_rd_skid #(
        .DATA_SIZE (DATA_SIZE)
    ) u_skid (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_clear     (w_skid_clear),
        .i_push      (w_read),
        .i_push_data (i_fifo_data),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_occupancy (w_occ)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        o_busy      = 1'b0;
        o_done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_state_nxt = (i_len != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                o_busy = 1'b1;
                // Leave on the edge that pops the last word so the skid can
                // drain while FLUSH is already active.
                if ((r_remaining == '0) || (w_read && (r_remaining == LEN_W'(1)))) begin
                    w_state_nxt = FLUSH;
                end
            end
            FLUSH: begin
                o_busy = 1'b1;
                // Look ahead one transfer so DONE directly follows the last word.
                if ((w_occ == 2'd0) || ((w_occ == 2'd1) && w_xfer)) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                o_busy      = 1'b1;
                o_done      = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_remaining <= '0;
        end else if (w_skid_clear) begin
            r_remaining <= i_len;
        end else if (w_read) begin
            r_remaining <= r_remaining - LEN_W'(1);
        end
    end

`ifdef FIFO_RD_STALL_CNT_EN
    logic [FIFO_RD_STALL_W-1:0] r_stall_cycles;

    assign o_stall_cycles = r_stall_cycles;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stall_cycles <= '0;
        end else if (w_start_acc) begin
            r_stall_cycles <= '0;
        end else if ((r_state == RUN) && (r_remaining != '0) && i_fifo_empty
                     && (r_stall_cycles != '1)) begin
            r_stall_cycles <= r_stall_cycles + FIFO_RD_STALL_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader with a behavioural show-ahead FIFO.
// Latency: n/a.
// Backpressure: bench drives i_ready patterns per scenario.
module tb_fifo_burst_reader;

    logic        clk;
    logic        rst_n;
    logic        i_start;
    logic [7:0]  i_len;
    logic        o_busy;
    logic        o_done;
    logic [7:0]  o_remaining;
    logic [15:0] i_fifo_data;
    logic        i_fifo_empty;
    logic        o_fifo_read;
    logic [15:0] o_data;
    logic        o_valid;
    logic        i_ready;
`ifdef FIFO_RD_STALL_CNT_EN
    logic [15:0] o_stall_cycles;
`endif

    int n_cmp = 0;
    int n_err = 0;

    fifo_burst_reader #(
        .DATA_SIZE (16),
        .LEN_W     (8)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_start        (i_start),
        .i_len          (i_len),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_remaining    (o_remaining),
        .i_fifo_data    (i_fifo_data),
        .i_fifo_empty   (i_fifo_empty),
        .o_fifo_read    (o_fifo_read),
        .o_data         (o_data),
        .o_valid        (o_valid),
        .i_ready        (i_ready)
`ifdef FIFO_RD_STALL_CNT_EN
        ,
        .o_stall_cycles (o_stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Show-ahead FIFO model: head word visible combinationally, popped on strobe.
    logic [15:0] fifo_mem [32];
    int          fifo_wr = 0;
    int          fifo_rd = 0;
    logic        fifo_flush = 1'b0;

    assign i_fifo_data  = fifo_mem[fifo_rd[4:0]];
    assign i_fifo_empty = (fifo_rd == fifo_wr);

    always @(posedge clk) begin
        if (fifo_flush) fifo_rd <= fifo_wr;
        else if (o_fifo_read) fifo_rd <= fifo_rd + 1;
    end

    // Monitor, sampled mid-cycle: counts events that happen at the next rising edge.
    int          rd_n = 0;
    int          rx_n = 0;
    int          done_n = 0;
    int          rd_empty_err = 0;
    int          stab_err = 0;
    logic        held = 1'b0;
    logic [15:0] held_dat = '0;
    logic [15:0] rx_log [256];

    always @(negedge clk) begin
        if (rst_n) begin
            if (o_fifo_read) begin
                rd_n = rd_n + 1;
                if (i_fifo_empty) rd_empty_err = rd_empty_err + 1;
            end
            if (o_valid && i_ready) begin
                rx_log[rx_n[7:0]] = o_data;
                rx_n = rx_n + 1;
            end
            if (o_done) done_n = done_n + 1;
            if (held && (o_data !== held_dat)) stab_err = stab_err + 1;
            held     = o_valid && !i_ready;
            held_dat = o_data;
        end else begin
            held = 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    task automatic push_word(input logic [15:0] v);
        fifo_mem[fifo_wr[4:0]] = v;
        fifo_wr = fifo_wr + 1;
    endtask

    task automatic flush_fifo();
        fifo_flush = 1'b1;
        @(posedge clk); #1;
        fifo_flush = 1'b0;
    endtask

    task automatic start_burst(input logic [7:0] len);
        i_start = 1'b1;
        i_len   = len;
        @(posedge clk); #1;
        i_start = 1'b0;
        i_len   = 8'd0;
    endtask

    task automatic wait_done(input int max_cyc, output int cyc);
        cyc = 0;
        for (int c = 1; c <= max_cyc; c++) begin
            @(posedge clk); #1;
            if (o_done) begin
                cyc = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        i_start = 1'b0;
        i_len   = 8'd0;
        i_ready = 1'b1;
        rst_n   = 1'b1;
        #1 rst_n = 1'b0;
        #3;
        n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", o_valid); end
        n_cmp++; if (o_fifo_read !== 1'b0) begin n_err++; $display("FAIL reset_read: got %b want 0", o_fifo_read); end
        n_cmp++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", o_busy); end
        n_cmp++; if (o_done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", o_done); end
        n_cmp++; if (o_remaining !== 8'd0) begin n_err++; $display("FAIL reset_remaining: got %0d want 0", o_remaining); end
        n_cmp++; if (o_data !== 16'h0000) begin n_err++; $display("FAIL reset_data: got %h want 0000", o_data); end
`ifdef FIFO_RD_STALL_CNT_EN
        n_cmp++; if (o_stall_cycles !== 16'd0) begin n_err++; $display("FAIL reset_stall: got %0d want 0", o_stall_cycles); end
`endif
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL reset_idle_after: busy got %b want 0", o_busy); end
    endtask

    task automatic test_basic_burst();
        int rd_b, rx_b, dn_b, done_at;
        flush_fifo();
        for (int i = 1; i <= 5; i++) push_word(16'(i));
        i_ready = 1'b1;
        rd_b = rd_n; rx_b = rx_n; dn_b = done_n;
        start_burst(8'd4);
        done_at = 0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (c == 1) begin
                n_cmp++; if (o_remaining !== 8'd3) begin n_err++; $display("FAIL basic_remaining_mid: got %0d want 3", o_remaining); end
            end
            if (o_done) begin
                done_at = c;
                break;
            end
        end
        n_cmp++; if (done_at != 5) begin n_err++; $display("FAIL basic_done_cycle: got %0d want 5", done_at); end
        n_cmp++; if (rd_n - rd_b != 4) begin n_err++; $display("FAIL basic_reads: got %0d want 4", rd_n - rd_b); end
        n_cmp++; if (rx_n - rx_b != 4) begin n_err++; $display("FAIL basic_xfers: got %0d want 4", rx_n - rx_b); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (rx_log[8'(rx_b + i)] !== 16'(i + 1)) begin
                n_err++; $display("FAIL basic_word%0d: got %h want %h", i, rx_log[8'(rx_b + i)], 16'(i + 1));
            end
        end
        n_cmp++; if (fifo_wr - fifo_rd != 1) begin n_err++; $display("FAIL basic_fifo_left: got %0d want 1", fifo_wr - fifo_rd); end
        @(posedge clk); #1;
        n_cmp++; if (done_n - dn_b != 1) begin n_err++; $display("FAIL basic_done_pulses: got %0d want 1", done_n - dn_b); end
        n_cmp++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL basic_busy_after: got %b want 0", o_busy); end
        n_cmp++; if (o_remaining !== 8'd0) begin n_err++; $display("FAIL basic_remaining_end: got %0d want 0", o_remaining); end
    endtask

    task automatic test_back_pressure();
        int rd_b, rx_b, st_b, maxbuf, nbuf, got;
        flush_fifo();
        for (int i = 0; i < 8; i++) push_word(16'h0010 + 16'(i));
        i_ready = 1'b1;
        rd_b = rd_n; rx_b = rx_n; st_b = stab_err;
        maxbuf = 0; got = 0;
        start_burst(8'd6);
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk); #1;
            nbuf = (rd_n - rd_b) - (rx_n - rx_b);
            if (nbuf > maxbuf) maxbuf = nbuf;
            if (o_done) begin
                got = 1;
                break;
            end
            i_ready = (c % 3 == 0);
        end
        i_ready = 1'b1;
        n_cmp++; if (got != 1) begin n_err++; $display("FAIL bp_done: got %0d want 1", got); end
        n_cmp++; if (maxbuf != 2) begin n_err++; $display("FAIL bp_max_buffered: got %0d want 2", maxbuf); end
        n_cmp++; if (stab_err - st_b != 0) begin n_err++; $display("FAIL bp_data_stable: got %0d changes want 0", stab_err - st_b); end
        n_cmp++; if (rd_n - rd_b != 6) begin n_err++; $display("FAIL bp_reads: got %0d want 6", rd_n - rd_b); end
        n_cmp++; if (rx_n - rx_b != 6) begin n_err++; $display("FAIL bp_xfers: got %0d want 6", rx_n - rx_b); end
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (rx_log[8'(rx_b + i)] !== 16'h0010 + 16'(i)) begin
                n_err++; $display("FAIL bp_word%0d: got %h want %h", i, rx_log[8'(rx_b + i)], 16'h0010 + 16'(i));
            end
        end
        n_cmp++; if (fifo_wr - fifo_rd != 2) begin n_err++; $display("FAIL bp_fifo_left: got %0d want 2", fifo_wr - fifo_rd); end
    endtask

    task automatic test_starvation();
        int rd_b, rx_b, er_b, cyc;
        flush_fifo();
        i_ready = 1'b1;
        rd_b = rd_n; rx_b = rx_n; er_b = rd_empty_err;
        start_burst(8'd3);
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk); #1;
            if (c == 3) begin
                n_cmp++; if (o_remaining !== 8'd3) begin n_err++; $display("FAIL starve_remaining: got %0d want 3", o_remaining); end
                n_cmp++; if (o_busy !== 1'b1) begin n_err++; $display("FAIL starve_busy: got %b want 1", o_busy); end
            end
        end
        n_cmp++; if (rd_n - rd_b != 0) begin n_err++; $display("FAIL starve_no_reads: got %0d want 0", rd_n - rd_b); end
        push_word(16'h0A01);
        push_word(16'h0A02);
        push_word(16'h0A03);
        wait_done(30, cyc);
        n_cmp++; if (cyc == 0) begin n_err++; $display("FAIL starve_done: got timeout want done"); end
        n_cmp++; if (rd_empty_err - er_b != 0) begin n_err++; $display("FAIL starve_read_empty: got %0d want 0", rd_empty_err - er_b); end
        n_cmp++; if (rx_n - rx_b != 3) begin n_err++; $display("FAIL starve_xfers: got %0d want 3", rx_n - rx_b); end
        n_cmp++; if (rx_log[8'(rx_b + 2)] !== 16'h0A03) begin n_err++; $display("FAIL starve_last_word: got %h want 0a03", rx_log[8'(rx_b + 2)]); end
`ifdef FIFO_RD_STALL_CNT_EN
        n_cmp++; if (o_stall_cycles !== 16'd5) begin n_err++; $display("FAIL starve_stall_cnt: got %0d want 5", o_stall_cycles); end
`endif
    endtask

    task automatic test_zero_len_ignored_start();
        int rd_b, rx_b, dn_b, cyc;
        @(posedge clk); #1;
        i_ready = 1'b1;
        rd_b = rd_n;
        start_burst(8'd0);
        n_cmp++; if (o_done !== 1'b1) begin n_err++; $display("FAIL zero_done: got %b want 1", o_done); end
        n_cmp++; if (o_busy !== 1'b1) begin n_err++; $display("FAIL zero_busy: got %b want 1", o_busy); end
`ifdef FIFO_RD_STALL_CNT_EN
        n_cmp++; if (o_stall_cycles !== 16'd0) begin n_err++; $display("FAIL zero_stall_clear: got %0d want 0", o_stall_cycles); end
`endif
        @(posedge clk); #1;
        n_cmp++; if (o_done !== 1'b0) begin n_err++; $display("FAIL zero_done_pulse: got %b want 0", o_done); end
        n_cmp++; if (rd_n - rd_b != 0) begin n_err++; $display("FAIL zero_reads: got %0d want 0", rd_n - rd_b); end

        flush_fifo();
        for (int i = 0; i < 6; i++) push_word(16'h0030 + 16'(i));
        rd_b = rd_n; rx_b = rx_n; dn_b = done_n;
        start_burst(8'd4);
        i_start = 1'b1;
        i_len   = 8'd9;
        @(posedge clk); #1;
        i_start = 1'b0;
        i_len   = 8'd0;
        wait_done(30, cyc);
        n_cmp++; if (cyc == 0) begin n_err++; $display("FAIL ign_done: got timeout want done"); end
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (rd_n - rd_b != 4) begin n_err++; $display("FAIL ign_reads: got %0d want 4", rd_n - rd_b); end
        n_cmp++; if (done_n - dn_b != 1) begin n_err++; $display("FAIL ign_done_pulses: got %0d want 1", done_n - dn_b); end
        n_cmp++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL ign_busy_after: got %b want 0", o_busy); end
        n_cmp++; if (rx_log[8'(rx_b + 3)] !== 16'h0033) begin n_err++; $display("FAIL ign_last_word: got %h want 0033", rx_log[8'(rx_b + 3)]); end
        n_cmp++; if (fifo_wr - fifo_rd != 2) begin n_err++; $display("FAIL ign_fifo_left: got %0d want 2", fifo_wr - fifo_rd); end
    endtask

    task automatic test_reset_mid_burst();
        int rd_b, rx_b, cyc, seen;
        flush_fifo();
        for (int i = 0; i < 8; i++) push_word(16'h0040 + 16'(i));
        i_ready = 1'b1;
        rd_b = rd_n;
        start_burst(8'd5);
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            if (rd_n - rd_b == 2) begin
                seen = 1;
                break;
            end
            @(posedge clk); #1;
        end
        n_cmp++; if (seen != 1) begin n_err++; $display("FAIL rst_two_reads: got timeout want 2 reads"); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL rst_mid_valid: got %b want 0", o_valid); end
        n_cmp++; if (o_fifo_read !== 1'b0) begin n_err++; $display("FAIL rst_mid_read: got %b want 0", o_fifo_read); end
        n_cmp++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL rst_mid_busy: got %b want 0", o_busy); end
        n_cmp++; if (o_remaining !== 8'd0) begin n_err++; $display("FAIL rst_mid_remaining: got %0d want 0", o_remaining); end
        n_cmp++; if (o_data !== 16'h0000) begin n_err++; $display("FAIL rst_mid_data: got %h want 0000", o_data); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (fifo_wr - fifo_rd != 6) begin n_err++; $display("FAIL rst_fifo_left: got %0d want 6", fifo_wr - fifo_rd); end
        rd_b = rd_n; rx_b = rx_n;
        start_burst(8'd2);
        wait_done(20, cyc);
        n_cmp++; if (cyc != 3) begin n_err++; $display("FAIL rst_new_done_cycle: got %0d want 3", cyc); end
        n_cmp++; if (rd_n - rd_b != 2) begin n_err++; $display("FAIL rst_new_reads: got %0d want 2", rd_n - rd_b); end
        n_cmp++; if (rx_log[8'(rx_b)] !== 16'h0042) begin n_err++; $display("FAIL rst_new_word0: got %h want 0042", rx_log[8'(rx_b)]); end
        n_cmp++; if (rx_log[8'(rx_b + 1)] !== 16'h0043) begin n_err++; $display("FAIL rst_new_word1: got %h want 0043", rx_log[8'(rx_b + 1)]); end
    endtask

    initial begin
        test_reset();
        test_basic_burst();
        test_back_pressure();
        test_starvation();
        test_zero_len_ignored_start();
        test_reset_mid_burst();
        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
